vx_local_mem_ctrl: RTL and testbench
====================================

Name: vx_local_mem_ctrl

Overview:
- Memory-side responder directly downstream of the Vortex top-level memory port.
- Accepts Vortex line requests into an in-order request queue and ages each entry by a fixed latency.
- Performs byte-enabled writes and full-line reads on an internal line-wide RAM, and returns read data with the original tag through a backpressured response register.
- Serves as the simulation local memory that Vortex talks to.

Parameters:
- DATA_WIDTH, 512, line width in bits; byte-enable width is DATA_WIDTH/8.
- ADDR_WIDTH, 26, line-address width.
- TAG_WIDTH, 56, request/response tag width.
- MEM_LINES_LOG2, 10, log2 of RAM lines implemented.
- LATENCY, 4, minimum cycles from accept to response; legal range 1..15.
- QUEUE_DEPTH, 4, request queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- mem_req_valid  in  1  request valid
- mem_req_rw  in  1  1 = write, 0 = read
- mem_req_byteen  in  DATA_WIDTH/8  write byte enables
- mem_req_addr  in  ADDR_WIDTH  line address
- mem_req_data  in  DATA_WIDTH  write data
- mem_req_tag  in  TAG_WIDTH  request tag
- mem_req_ready  out  1  queue can accept
- mem_rsp_valid  out  1  response valid
- mem_rsp_data  out  DATA_WIDTH  read data
- mem_rsp_tag  out  TAG_WIDTH  tag of the response
- mem_rsp_ready  in  1  Vortex accepts response
- busy  out  1  queue non-empty or response pending
- tb_addr_out_of_bounds  out  1  sticky flag: address at or above 2^MEM_LINES_LOG2 seen

Behaviour:
- Reset: asserting reset low asynchronously clears queue pointers, count, and all countdowns.
  - mem_rsp_valid=0, mem_rsp_data=0, mem_rsp_tag=0, tb_addr_out_of_bounds=0, busy=0.
  - mem_req_ready=1 once reset deasserts.
  - RAM contents are not reset.
  - Reset mid-operation discards all queued requests and any pending response.
- Accept: a request is accepted in a cycle when mem_req_valid && mem_req_ready.
  - mem_req_ready = queue not full, registered-count based, with no same-cycle bypass. A full queue stays not-ready in the cycle it pops.
  - On accept, the entry stores rw, byteen, addr, data, and tag, and its countdown loads LATENCY-1.
- Aging: every occupied entry's countdown decrements each cycle, saturating at 0. The head is eligible when its countdown is 0.
- Pop rules, strict FIFO order, at most one pop per cycle:
  - Write head: pops when eligible. RAM bytes with byteen=1 are updated at the pop edge; the rest are unchanged. No response.
  - Read head: pops when eligible and the response slot is free, i.e. !mem_rsp_valid || mem_rsp_ready. At the pop edge the response register loads RAM[addr] and the tag, and mem_rsp_valid=1.
- Latency: with no contention, a read accepted in cycle T has mem_rsp_valid high in cycle T+LATENCY+1.
- Response handshake:
  - mem_rsp_valid holds, with data and tag stable, until mem_rsp_ready.
  - On handshake with no new load, mem_rsp_valid=0. Back-to-back handshake and load gives one response per cycle.
- Read-after-write: a read queued behind a write to the same line returns the written data, because order is FIFO.
- Out of bounds: addr >= 2^MEM_LINES_LOG2 sets tb_addr_out_of_bounds (sticky until reset).
  - An OOB write is dropped.
  - An OOB read returns all-zero data with its tag.
  - OOB requests keep normal latency and order.
- Simultaneous accept and pop in the same cycle: count is unchanged, and both entries are updated correctly.
- busy = (count != 0) || mem_rsp_valid.

Optional Feature:
- Macro: VX_LMEM_WRITE_ACK_EN.
- Defined: a write head also requires a free response slot. At its pop it loads a response with the write's tag and all-zero data, so every request receives exactly one response.
- Undefined: writes produce no response, as described above.

Test Plan:
- Single read latency, LATENCY=4, after a write of 0xA5 in byte 0 to addr 3 → read of addr 3 with tag 0x11 accepted in cycle T; mem_rsp_valid high in cycle T+5, data byte0=0xA5, tag 0x11.
- Byte enable: write all-0xFF to addr 5, then write 0x00 with byteen=0x...0F; read addr 5 → bytes 0-3 are 0x00, bytes 4-63 are 0xFF.
- Backpressure: issue 6 reads with tags 1..6 while mem_rsp_ready=0 → mem_req_ready drops after 4 accepts plus the held response. Raise ready → tags 1..6 delivered in order, one per cycle, none lost.
- Out of bounds: read addr 0x400 with MEM_LINES_LOG2=10 → response data 0, tag returned, tb_addr_out_of_bounds=1 and stays 1. An OOB write leaves line 0 unchanged.
- Reset mid-flight: 3 reads queued, then reset pulsed low for 1 cycle → mem_rsp_valid=0, busy=0, mem_req_ready=1, and no stale response afterwards.
- VX_LMEM_WRITE_ACK_EN defined: write with tag 0x22 → response with tag 0x22 and data 0 after LATENCY+1 cycles. With the macro undefined → no response.

Source files
------------

// File: rtl/vx_local_mem_ctrl.sv
// rtl/vx_local_mem_ctrl.sv - line-wide local memory responder behind the Vortex memory port
// Optional: define VX_LMEM_WRITE_ACK_EN to make every write return a zero-data response with its tag.
module vx_local_mem_ctrl #(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 26,
  parameter int TAG_WIDTH      = 56,
  parameter int MEM_LINES_LOG2 = 10,
  parameter int LATENCY        = 4,
  parameter int QUEUE_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic                    busy,
  output logic                    tb_addr_out_of_bounds
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int PTR_W     = $clog2(QUEUE_DEPTH);
  localparam int MEM_LINES = 1 << MEM_LINES_LOG2;
  localparam logic [3:0]   CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(QUEUE_DEPTH);

  logic                  q_rw     [QUEUE_DEPTH];
  logic [BE_WIDTH-1:0]   q_byteen [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_addr   [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] q_data   [QUEUE_DEPTH];
  logic [TAG_WIDTH-1:0]  q_tag    [QUEUE_DEPTH];
  logic [3:0]            q_cnt    [QUEUE_DEPTH];

  logic [DATA_WIDTH-1:0] ram [MEM_LINES];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic                      accept;
  logic                      head_valid;
  logic                      head_eligible;
  logic                      head_rw;
  logic [ADDR_WIDTH-1:0]     head_addr;
  logic [MEM_LINES_LOG2-1:0] head_line;
  logic                      head_oob;
  logic                      req_oob;
  logic                      rsp_free;
  logic                      pop;
  logic                      rsp_load;
  logic                      ram_we;
  logic [DATA_WIDTH-1:0]     rsp_data_next;

  // Ready is derived from the registered count only; a pop never frees a slot in the same cycle.
  assign mem_req_ready = (count != COUNT_FULL);
  assign accept        = mem_req_valid && mem_req_ready;
  assign req_oob       = |mem_req_addr[ADDR_WIDTH-1:MEM_LINES_LOG2];

  assign head_valid    = (count != '0);
  assign head_rw       = q_rw[rd_ptr];
  assign head_addr     = q_addr[rd_ptr];
  assign head_line     = head_addr[MEM_LINES_LOG2-1:0];
  assign head_oob      = |head_addr[ADDR_WIDTH-1:MEM_LINES_LOG2];
  assign head_eligible = head_valid && (q_cnt[rd_ptr] == 4'd0);
  assign rsp_free      = !mem_rsp_valid || mem_rsp_ready;

`ifdef VX_LMEM_WRITE_ACK_EN
  assign pop      = head_eligible && rsp_free;
  assign rsp_load = pop;
`else
  assign pop      = head_eligible && (head_rw || rsp_free);
  assign rsp_load = pop && !head_rw;
`endif

  assign ram_we        = pop && head_rw && !head_oob;
  assign rsp_data_next = (head_rw || head_oob) ? '0 : ram[head_line];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Free slots keep counting down too; harmless since every accept reloads its slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) q_cnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (accept && (wr_ptr == PTR_W'(i))) q_cnt[i] <= CNT_LOAD;
        else if (q_cnt[i] != 4'd0)           q_cnt[i] <= q_cnt[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      q_rw[wr_ptr]     <= mem_req_rw;
      q_byteen[wr_ptr] <= mem_req_byteen;
      q_addr[wr_ptr]   <= mem_req_addr;
      q_data[wr_ptr]   <= mem_req_data;
      q_tag[wr_ptr]    <= mem_req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (q_byteen[rd_ptr][b]) ram[head_line][b*8 +: 8] <= q_data[rd_ptr][b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_rsp_valid <= 1'b0;
      mem_rsp_data  <= '0;
      mem_rsp_tag   <= '0;
    end else if (rsp_load) begin
      mem_rsp_valid <= 1'b1;
      mem_rsp_data  <= rsp_data_next;
      mem_rsp_tag   <= q_tag[rd_ptr];
    end else if (mem_rsp_ready) begin
      mem_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 tb_addr_out_of_bounds <= 1'b0;
    else if (accept && req_oob) tb_addr_out_of_bounds <= 1'b1;
  end

  assign busy = head_valid || mem_rsp_valid;

endmodule

// File: tb/tb_vx_local_mem_ctrl.sv
// tb/tb_vx_local_mem_ctrl.sv - table-driven bench for vx_local_mem_ctrl
module tb_vx_local_mem_ctrl;

  localparam int DW  = 512;
  localparam int AW  = 26;
  localparam int TW  = 56;
  localparam int BEW = DW / 8;
  localparam int LAT = 4;

  typedef struct {
    logic           rw;
    logic [AW-1:0]  addr;
    logic [BEW-1:0] byteen;
    logic [DW-1:0]  data;
    logic [TW-1:0]  tag;
    logic [DW-1:0]  exp_data;
    logic           exp_oob;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           mem_req_valid;
  logic           mem_req_rw;
  logic [BEW-1:0] mem_req_byteen;
  logic [AW-1:0]  mem_req_addr;
  logic [DW-1:0]  mem_req_data;
  logic [TW-1:0]  mem_req_tag;
  logic           mem_req_ready;
  logic           mem_rsp_valid;
  logic [DW-1:0]  mem_rsp_data;
  logic [TW-1:0]  mem_rsp_tag;
  logic           mem_rsp_ready;
  logic           busy;
  logic           tb_addr_out_of_bounds;

  int n_checks = 0;
  int n_pass   = 0;

  vx_local_mem_ctrl dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready), .busy(busy),
    .tb_addr_out_of_bounds(tb_addr_out_of_bounds)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] fill(input logic [7:0] b);
    return {BEW{b}};
  endfunction

  function automatic vec_t mk(input logic rw, input logic [AW-1:0] addr, input logic [BEW-1:0] be,
                              input logic [DW-1:0] data, input logic [TW-1:0] tag,
                              input logic [DW-1:0] exp_data, input logic exp_oob);
    vec_t v;
    v.rw = rw; v.addr = addr; v.byteen = be; v.data = data; v.tag = tag;
    v.exp_data = exp_data; v.exp_oob = exp_oob;
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge (or after the bound).
  task automatic issue(input logic rw, input logic [AW-1:0] addr, input logic [BEW-1:0] be,
                       input logic [DW-1:0] data, input logic [TW-1:0] tag, input int bound,
                       output bit ok);
    mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = addr;
    mem_req_byteen = be; mem_req_data = data; mem_req_tag = tag;
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (mem_req_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    mem_req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string id);
    bit ok;
    bit expect_rsp;
    bit seen;
    int lat;
    issue(v.rw, v.addr, v.byteen, v.data, v.tag, 20, ok);
    check({id, " accept"}, DW'(ok), DW'(1));
    check({id, " busy"}, DW'(busy), DW'(1));
`ifdef VX_LMEM_WRITE_ACK_EN
    expect_rsp = 1'b1;
`else
    expect_rsp = !v.rw;
`endif
    if (expect_rsp) begin
      lat = 0;
      while (!mem_rsp_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      if (!mem_rsp_valid) lat = -1;
      check({id, " latency"}, DW'(lat), DW'(LAT));
      check({id, " data"}, mem_rsp_data, v.rw ? '0 : v.exp_data);
      check({id, " tag"}, DW'(mem_rsp_tag), DW'(v.tag));
      @(negedge clk);
      check({id, " valid_drop"}, DW'(mem_rsp_valid), DW'(0));
    end else begin
      seen = 1'b0;
      repeat (LAT + 3) begin
        @(negedge clk);
        if (mem_rsp_valid) seen = 1'b1;
      end
      check({id, " no_write_rsp"}, DW'(seen), DW'(0));
    end
    check({id, " oob_flag"}, DW'(tb_addr_out_of_bounds), DW'(v.exp_oob));
  endtask

  vec_t vecs[13];
  logic [TW-1:0] got_tags[6];
  int            got_cyc[6];

  initial begin
    bit ok;
    bit ok6;
    bit seen;
    int got;
    int cyc;
    logic [DW-1:0] all_be_ff;

    all_be_ff = fill(8'hFF);
    vecs[0]  = mk(1'b1, 26'd3,        '1,      '0,          56'h01, '0, 1'b0);
    vecs[1]  = mk(1'b1, 26'd3,        64'h1,   512'hA5,     56'h02, '0, 1'b0);
    vecs[2]  = mk(1'b0, 26'd3,        '0,      '0,          56'h11, 512'hA5, 1'b0);
    vecs[3]  = mk(1'b1, 26'd5,        '1,      fill(8'hFF), 56'h03, '0, 1'b0);
    vecs[4]  = mk(1'b1, 26'd5,        64'hF,   '0,          56'h04, '0, 1'b0);
    vecs[5]  = mk(1'b0, 26'd5,        '0,      '0,          56'h12, all_be_ff & ~512'hFFFFFFFF, 1'b0);
    vecs[6]  = mk(1'b1, 26'd0,        '1,      fill(8'h5A), 56'h22, '0, 1'b0);
    vecs[7]  = mk(1'b1, 26'h400,      '1,      fill(8'hFF), 56'h06, '0, 1'b1);
    vecs[8]  = mk(1'b0, 26'd0,        '0,      '0,          56'h14, fill(8'h5A), 1'b1);
    vecs[9]  = mk(1'b0, 26'h400,      '0,      '0,          56'h15, '0, 1'b1);
    vecs[10] = mk(1'b1, 26'h3FF,      '1,      fill(8'hC3), 56'h07, '0, 1'b1);
    vecs[11] = mk(1'b0, 26'h3FF,      '0,      '0,          56'h16, fill(8'hC3), 1'b1);
    vecs[12] = mk(1'b0, 26'h3FFFFFF,  '0,      '0,          56'h17, '0, 1'b1);

    reset = 1'b0; mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_byteen = '0;
    mem_req_addr = '0; mem_req_data = '0; mem_req_tag = '0; mem_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset rsp_valid", DW'(mem_rsp_valid), DW'(0));
    check("reset rsp_data", mem_rsp_data, '0);
    check("reset rsp_tag", DW'(mem_rsp_tag), DW'(0));
    check("reset oob", DW'(tb_addr_out_of_bounds), DW'(0));
    check("reset busy", DW'(busy), DW'(0));
    reset = 1'b1;
    @(negedge clk);
    check("reset req_ready", DW'(mem_req_ready), DW'(1));

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: five accepts fit (four queued plus one held in the response register).
    mem_rsp_ready = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      issue(1'b0, 26'd0, '0, '0, TW'(t), 20, ok);
      check($sformatf("bp accept%0d", t), DW'(ok), DW'(1));
    end
    issue(1'b0, 26'd0, '0, '0, TW'(6), 12, ok);
    check("bp sixth_stalls", DW'(ok), DW'(0));
    check("bp req_ready_low", DW'(mem_req_ready), DW'(0));
    check("bp held_valid", DW'(mem_rsp_valid), DW'(1));
    check("bp held_tag", DW'(mem_rsp_tag), DW'(1));
    fork
      issue(1'b0, 26'd0, '0, '0, TW'(6), 40, ok6);
      begin
        mem_rsp_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 6 && cyc < 60) begin
          if (mem_rsp_valid) begin
            got_tags[got] = mem_rsp_tag;
            got_cyc[got]  = cyc;
            got++;
          end
          @(negedge clk);
          cyc++;
        end
      end
    join
    check("bp sixth_accept", DW'(ok6), DW'(1));
    check("bp rsp_count", DW'(got), DW'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < got) begin
        check($sformatf("bp order%0d", i), DW'(got_tags[i]), DW'(i + 1));
        if (i < 5) check($sformatf("bp cycle%0d", i), DW'(got_cyc[i]), DW'(got_cyc[0] + i));
      end
    end
    repeat (2) @(negedge clk);
    check("bp idle_busy", DW'(busy), DW'(0));

    // Reset while three reads are still aging in the queue.
    for (int t = 0; t < 3; t++) issue(1'b0, 26'd0, '0, '0, TW'(8'h31 + t), 10, ok);
    check("rst busy_before", DW'(busy), DW'(1));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst rsp_valid", DW'(mem_rsp_valid), DW'(0));
    check("rst busy", DW'(busy), DW'(0));
    check("rst req_ready", DW'(mem_req_ready), DW'(1));
    check("rst oob_cleared", DW'(tb_addr_out_of_bounds), DW'(0));
    seen = 1'b0;
    repeat (LAT + 6) begin
      @(negedge clk);
      if (mem_rsp_valid) seen = 1'b1;
    end
    check("rst no_stale_rsp", DW'(seen), DW'(0));

    // RAM contents survive reset.
    run_vec(mk(1'b0, 26'd5, '0, '0, 56'h40, all_be_ff & ~512'hFFFFFFFF, 1'b0), "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
